// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle add/sub/and/or, iterative shift-add multiply.
// Multiply stalls upstream via ready_o for WIDTH cycles.
module alu_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       ALUCtrl_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             zero_o,
    output logic             busy_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE,
        MUL
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] data_q;
    logic [CW-1:0]    cnt_q;
    logic             valid_q;
    logic             zero_q;

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] acc_d;
    logic             is_mul;

    assign is_mul = (ALUCtrl_i == 3'b101);

    always_comb begin
        res_d = '0;
        case (ALUCtrl_i)
            3'b001:  res_d = data1_i + data2_i;
            3'b010:  res_d = data1_i - data2_i;
            3'b011:  res_d = data1_i & data2_i;
            3'b100:  res_d = data1_i | data2_i;
            default: res_d = '0;
        endcase
    end

    // One shift-add step; the final step's sum is the product.
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            data_q   <= '0;
            zero_q   <= 1'b1;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (is_mul) begin
                            mcand_q  <= data1_i;
                            mplier_q <= data2_i;
                            acc_q    <= '0;
                            cnt_q    <= '0;
                            state_q  <= MUL;
                        end else begin
                            data_q  <= res_d;
                            zero_q  <= (res_d == '0);
                            valid_q <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        data_q  <= acc_d;
                        zero_q  <= (acc_d == '0);
                        valid_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign ready_o = (state_q == IDLE);
    assign busy_o  = (state_q == MUL);
    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign zero_o  = zero_q;

endmodule

// File: doc/alu_exec.md
# alu_exec

Execute-stage datapath that consumes the 3-bit operation code from the ALU control decoder and produces a registered result for the following pipeline stage. Add, subtract, AND and OR complete in one cycle. Multiply is a WIDTH-cycle iterative shift-add that stalls upstream through a ready/valid handshake. The block sits directly downstream of the ALU control decoder and in parallel with the register-file read path.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  operands and op code present this cycle
- ready_o  out  1  block can accept a new operation this cycle
- ALUCtrl_i  in  3  operation code: 001 add, 010 sub, 011 and, 100 or, 101 mul, all other codes undefined
- data1_i  in  WIDTH  operand A (multiplicand for mul)
- data2_i  in  WIDTH  operand B (multiplier for mul)
- valid_o  out  1  one-cycle pulse: data_o/zero_o carry a new result
- data_o  out  WIDTH  registered result; holds its value between pulses
- zero_o  out  1  registered, equal to (data_o == 0)
- busy_o  out  1  multiply in progress; always equal to !ready_o

## Operation
- States: IDLE, MUL. Reset enters IDLE.
- Acceptance: an operation is accepted on a rising edge where valid_i && ready_o. valid_i while ready_o=0 is ignored; upstream holds its inputs.
- IDLE, accepted non-mul op:
  - data_o <= result; zero_o <= (result==0); valid_o <= 1.
  - Stay in IDLE; ready_o stays 1, so one operation per cycle is possible.
- Results:
  - add: A+B mod 2^WIDTH.
  - sub: A−B mod 2^WIDTH.
  - and / or: bitwise.
  - Undefined codes: result 0, zero_o=1, valid_o still pulses.
- No overflow or carry output is produced.
- IDLE, accepted mul:
  - Load mcand<=A, mplier<=B, acc<=0, cnt<=0.
  - Go to MUL; valid_o <= 0.
- MUL, each edge:
  - If mplier[0], acc <= acc+mcand (mod 2^WIDTH).
  - mcand <= mcand<<1; mplier <= mplier>>1; cnt <= cnt+1.
- MUL exit: on the edge where cnt==WIDTH-1, write the final sum to data_o, set zero_o accordingly, set valid_o<=1, return to IDLE.
- Mul result is the low WIDTH bits of the product, which is the same for signed and unsigned operands. The high half is discarded.
- cnt width is $clog2(WIDTH). There is no early termination: multiply always takes WIDTH iterations.
- valid_o is cleared on every edge where no result is produced.
- While in MUL: data_o and zero_o keep the previous result. acc and mcand are internal only.

## Timing
- Reset (asynchronous, immediate, any state including mid-multiply):
  - State IDLE, ready_o=1, busy_o=0, valid_o=0, data_o=0, zero_o=1.
  - Internal acc, mcand, mplier and cnt are cleared.
  - An aborted multiply produces no valid_o.
- Single-cycle ops: accepted at edge E0, result and valid_o visible in the cycle after E0 (latency 1). Back-to-back ops give a valid_o pulse every cycle.
- Multiply:
  - Accepted at edge E0; ready_o=0 from after E0 until after edge E_WIDTH.
  - valid_o and the result are visible after E_WIDTH (latency WIDTH edges).
  - ready_o returns to 1 in the same cycle valid_o is high, so a new op is accepted at E_WIDTH+1.
- ready_o and busy_o are decoded from the registered state only; there is no combinational path from valid_i.

## Test plan
- Reset then add: A=5, B=7, code 001 for one cycle -> next cycle valid_o=1, data_o=12, zero_o=0; valid_o=0 the cycle after.
- Sub: 3−5 -> data_o=0xFFFFFFFE, zero_o=0. Then 9−9 on the next cycle -> data_o=0, zero_o=1. Valid_o is high for both consecutive cycles.
- Back-to-back and/or/undefined: 0xF0F0F0F0 & 0xFF00FF00 -> 0xF000F000; | -> 0xFFF0FFF0; code 111 -> data_o=0, zero_o=1. Three consecutive valid_o pulses.
- Multiply:
  - 6×7 -> ready_o=0 for exactly 32 cycles; a valid_i pulse with add 1+1 mid-multiply is ignored.
  - valid_o=1 with data_o=42 after the 32nd edge.
  - data_o keeps its prior value throughout the multiply.
- Wrap multiply: 0xFFFFFFFF×3 -> data_o=0xFFFFFFFD. 0x10000×0x10000 -> data_o=0, zero_o=1.
- Reset mid-multiply: start 6×7, assert rst_i low at cycle 10 -> immediately ready_o=1, data_o=0, zero_o=1, no valid_o. After release, add 2+2 -> 4 with latency 1.
